op_sequencer: RTL and testbench
===============================

// Module: op_sequencer
// PURPOSE
//   Upstream issue stage for the 2-register datapath (op/dest -> R0/R1). Holds a
//   small program of datapath instructions and, on start, drives op/dest one
//   instruction per accepted cycle, with per-instruction repeat counts.
//   Replaces hand-written op/dest stimulus; the datapath consumes op/dest directly.
// PARAMETERS
//   DEPTH   8   program memory entries (power of 2)
//   PC_W    3   log2(DEPTH)
// PORTS
//   clk          in   1       rising-edge clock
//   reset        in   1       synchronous, active-high
//   wr_en        in   1       program write strobe (honoured in IDLE only)
//   wr_addr      in   PC_W    program write address
//   wr_data      in   5       instr: [4:3] op, [2] dest, [1:0] rep (issue rep+1 times)
//   prog_len     in   PC_W+1  number of instructions to run (0..DEPTH), sampled on start
//   start        in   1       begin execution (honoured in IDLE only)
//   abort        in   1       stop execution, return to IDLE
//   issue_ready  in   1       datapath accepts current op this cycle
//   op           out  2       datapath opcode; 2'b00 (NOP) whenever issue_valid=0
//   dest         out  1       datapath destination select; 0 whenever issue_valid=0
//   issue_valid  out  1       op/dest valid
//   pc           out  PC_W    index of instruction being issued
//   busy         out  1       high in RUN
//   done         out  1       one-cycle pulse on normal completion
// BEHAVIOUR
//   - Reset: state IDLE; op=0, dest=0, issue_valid=0, pc=0, busy=0, done=0,
//     rep_cnt=0, len=0. Program memory not cleared (contents retained).
//   - All outputs registered. States: IDLE, RUN, DONE.
//   - IDLE: wr_en writes mem[wr_addr]<=wr_data. start (and !wr_en):
//       prog_len==0 -> DONE next edge, no issue;
//       prog_len>DEPTH -> treated as DEPTH;
//       else after that edge: RUN, pc=0, rep_cnt=0, busy=1, issue_valid=1,
//       op/dest=mem[0]. Start-to-first-valid latency: 1 cycle.
//     start with wr_en same cycle: write performed, start ignored.
//   - RUN: issue completes on edge with issue_valid & issue_ready:
//       rep_cnt<rep -> rep_cnt++, same op/dest held valid;
//       else pc==len-1 -> DONE: issue_valid=0, op=0, dest=0, busy=0;
//       else pc++, rep_cnt=0, op/dest=mem[pc+1].
//     issue_ready=0 -> all state and outputs held (no timeout).
//     wr_en and start ignored in RUN.
//   - abort in RUN (priority over completion): next edge IDLE, issue_valid=0,
//     op=0, dest=0, busy=0, pc=0; no done pulse. abort in IDLE/DONE: no effect.
//   - DONE: done=1 for exactly one cycle, then IDLE (done=0). pc cleared to 0.
//   - reset has priority over everything, incl. mid-RUN: outputs to reset values
//     next edge, no done pulse.
//   - Total issues in a run = sum over i<len of (rep_i+1); DEPTH=8, rep=3 -> 32 max.
// TESTING
//   1 Load mem[0]=01_0_01, mem[1]=10_1_00, len=2, ready=1, start -> op/dest seq
//     (01,0),(01,0),(10,1) on 3 consecutive cycles, then op=00 valid=0, done 1 cycle.
//   2 Same program, ready low 2 cycles during 2nd issue -> (01,0) held 2 extra
//     cycles; still exactly 3 accepted issues, done once.
//   3 prog_len=0, start -> no issue_valid, done pulses cycle after start, busy stays 0.
//   4 8-entry program all rep=3, ready=1 -> 32 accepted issues, pc 0..7, then done.
//   5 abort at 2nd issue of a 4-instr run -> valid=0, busy=0 next cycle, no done;
//     restart -> sequence begins again at pc=0.
//   6 reset asserted mid-RUN; wr_en during RUN to mem[0]; start+wr_en together
//     -> all outputs reset values; RUN write ignored; start ignored, write applied.

Source files
------------

// File: rtl/op_sequencer_if.sv
// Bus bundle between the op sequencer and its host/datapath side:
// program load, run control and the op/dest issue handshake.
interface op_sequencer_if #(
   parameter int unsigned PC_W = 3
);
   logic            wr_en;
   logic [PC_W-1:0] wr_addr;
   logic [4:0]      wr_data;
   logic [PC_W:0]   prog_len;
   logic            start;
   logic            abort;
   logic            issue_ready;
   logic [1:0]      op;
   logic            dest;
   logic            issue_valid;
   logic [PC_W-1:0] pc;
   logic            busy;
   logic            done;

   modport master (
      output wr_en, wr_addr, wr_data, prog_len, start, abort, issue_ready,
      input  op, dest, issue_valid, pc, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, prog_len, start, abort, issue_ready,
      output op, dest, issue_valid, pc, busy, done
   );
endinterface

// File: rtl/op_sequencer.sv
// Issue stage for the 2-register datapath: stores a short op/dest program and
// replays it one accepted instruction per cycle, honouring per-entry repeat counts.
module op_sequencer #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PC_W  = 3
) (
   input  logic            clk,
   input  logic            reset,
   op_sequencer_if.slave   bus
);
   localparam int unsigned LEN_W = PC_W + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [4:0]      mem [DEPTH];
   logic [PC_W-1:0] pc_q, pc_d;
   logic [1:0]      rep_q, rep_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [1:0]      op_q, op_d;
   logic            dest_q, dest_d;
   logic            valid_q, valid_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic [4:0]      cur_instr;
   logic [4:0]      nxt_instr;
   logic [4:0]      first_instr;

   // Program memory: no reset, writable only while idle
   always_ff @(posedge clk) begin
      if (!reset && state_q == IDLE && bus.wr_en) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   assign cur_instr   = mem[pc_q];
   assign nxt_instr   = mem[pc_q + PC_W'(1)];
   assign first_instr = mem[0];

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      rep_d   = rep_q;
      len_d   = len_q;
      op_d    = op_q;
      dest_d  = dest_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start && !bus.wr_en) begin
               if (bus.prog_len == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = RUN;
                  len_d   = (bus.prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.prog_len;
                  pc_d    = '0;
                  rep_d   = '0;
                  busy_d  = 1'b1;
                  valid_d = 1'b1;
                  op_d    = first_instr[4:3];
                  dest_d  = first_instr[2];
               end
            end
         end
         RUN: begin
            // Abort wins over a completing handshake in the same cycle
            if (bus.abort) begin
               state_d = IDLE;
               pc_d    = '0;
               rep_d   = '0;
               valid_d = 1'b0;
               op_d    = 2'b00;
               dest_d  = 1'b0;
               busy_d  = 1'b0;
            end else if (valid_q && bus.issue_ready) begin
               if (rep_q < cur_instr[1:0]) begin
                  rep_d = rep_q + 2'd1;
               end else if ({1'b0, pc_q} == len_q - LEN_W'(1)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  valid_d = 1'b0;
                  op_d    = 2'b00;
                  dest_d  = 1'b0;
                  busy_d  = 1'b0;
               end else begin
                  pc_d   = pc_q + PC_W'(1);
                  rep_d  = '0;
                  op_d   = nxt_instr[4:3];
                  dest_d = nxt_instr[2];
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            pc_d    = '0;
            rep_d   = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         rep_q   <= '0;
         len_q   <= '0;
         op_q    <= 2'b00;
         dest_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         rep_q   <= rep_d;
         len_q   <= len_d;
         op_q    <= op_d;
         dest_q  <= dest_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.op          = op_q;
   assign bus.dest        = dest_q;
   assign bus.issue_valid = valid_q;
   assign bus.pc          = pc_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
endmodule

// File: tb/tb_op_sequencer.sv
// Scoreboard bench for op_sequencer: stimulus queues expected issues/done pulses,
// a negedge monitor pops them as the DUT accepts issues or pulses done.
module tb_op_sequencer;
   typedef struct packed {
      logic       is_done;
      logic [1:0] op;
      logic       dest;
      logic [2:0] pc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   op_sequencer_if #(.PC_W(3)) bus ();

   op_sequencer #(.DEPTH(8), .PC_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted issue or done pulse must match the queue head
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (bus.issue_valid && bus.issue_ready && !bus.abort) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue: got op=%0d dest=%0d pc=%0d expected none",
                        bus.op, bus.dest, bus.pc);
            end else begin
               e = sb.pop_front();
               chk("issue", 32'({1'b0, bus.op, bus.dest, bus.pc}), 32'(e));
            end
         end
         if (bus.done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected none");
            end else begin
               e = sb.pop_front();
               chk("done", 32'({1'b1, bus.op, bus.dest, bus.issue_valid, bus.busy}),
                   32'({e.is_done, 2'b00, 1'b0, 1'b0, 1'b0}));
            end
         end
         if (!bus.issue_valid) chk("idle_nop", 32'({bus.op, bus.dest}), 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [4:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   task automatic push_issue(input logic [4:0] instr, input logic [2:0] pc);
      exp_t e;
      e.is_done = 1'b0;
      e.op      = instr[4:3];
      e.dest    = instr[2];
      e.pc      = pc;
      sb.push_back(e);
   endtask

   task automatic push_prog(input logic [4:0] instr, input logic [2:0] pc);
      for (int r = 0; r <= int'(instr[1:0]); r++) push_issue(instr, pc);
   endtask

   task automatic push_done();
      exp_t e;
      e = '0;
      e.is_done = 1'b1;
      sb.push_back(e);
   endtask

   task automatic start_run(input logic [3:0] len);
      bus.prog_len = len;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
   endtask

   // Wait (bounded) for the scoreboard to empty, then idle a little longer
   task automatic drain(input string name, input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d pending expected 0", name, sb.size());
         sb.delete();
      end
      tick();
      tick();
   endtask

   logic [4:0] p5 [4];
   logic [4:0] d;

   initial begin
      reset           = 1'b1;
      bus.wr_en       = 1'b0;
      bus.wr_addr     = '0;
      bus.wr_data     = '0;
      bus.prog_len    = '0;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.issue_ready = 1'b1;
      tick();
      tick();
      chk("rst_outputs", 32'({bus.op, bus.dest, bus.issue_valid, bus.pc, bus.busy, bus.done}), 32'd0);
      reset = 1'b0;
      tick();

      // 1: two instructions, first repeated once
      wr(3'd0, 5'b01_0_01);
      wr(3'd1, 5'b10_1_00);
      push_prog(5'b01_0_01, 3'd0);
      push_prog(5'b10_1_00, 3'd1);
      push_done();
      start_run(4'd2);
      chk("t1_latency", 32'({bus.issue_valid, bus.busy, bus.op}), 32'({1'b1, 1'b1, 2'b01}));
      drain("t1", 20);
      chk("t1_idle", 32'({bus.busy, bus.done, bus.issue_valid}), 32'd0);

      // 2: back-pressure during the second issue
      push_prog(5'b01_0_01, 3'd0);
      push_prog(5'b10_1_00, 3'd1);
      push_done();
      start_run(4'd2);
      tick();
      bus.issue_ready = 1'b0;
      tick();
      chk("t2_hold1", 32'({bus.issue_valid, bus.op, bus.dest}), 32'({1'b1, 2'b01, 1'b0}));
      tick();
      chk("t2_hold2", 32'({bus.issue_valid, bus.op, bus.dest, bus.pc}), 32'({1'b1, 2'b01, 1'b0, 3'd0}));
      bus.issue_ready = 1'b1;
      drain("t2", 20);

      // 3: empty program goes straight to done
      push_done();
      start_run(4'd0);
      chk("t3_done", 32'({bus.issue_valid, bus.busy, bus.done}), 32'({1'b0, 1'b0, 1'b1}));
      drain("t3", 5);
      chk("t3_after", 32'({bus.done, bus.busy}), 32'd0);

      // 4: full 8-entry program, rep=3 everywhere (32 issues), then clamped length
      for (int i = 0; i < 8; i++) begin
         d = {2'((i % 3) + 1), 1'(i & 1), 2'b11};
         wr(3'(i), d);
      end
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 8; i++) push_prog({2'((i % 3) + 1), 1'(i & 1), 2'b11}, 3'(i));
         push_done();
         start_run(k == 0 ? 4'd8 : 4'd13);
         drain(k == 0 ? "t4" : "t4_clamp", 60);
      end

      // 5: abort during the second issue, then restart from pc 0
      p5[0] = 5'b01_1_00;
      p5[1] = 5'b10_0_00;
      p5[2] = 5'b11_1_00;
      p5[3] = 5'b01_0_00;
      for (int i = 0; i < 4; i++) wr(3'(i), p5[i]);
      push_prog(p5[0], 3'd0);
      start_run(4'd4);
      tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      chk("t5_abort", 32'({bus.issue_valid, bus.busy, bus.pc, bus.done}), 32'd0);
      drain("t5_abort", 5);
      for (int i = 0; i < 4; i++) push_prog(p5[i], 3'(i));
      push_done();
      start_run(4'd4);
      chk("t5_restart_pc", 32'({bus.issue_valid, bus.pc}), 32'({1'b1, 3'd0}));
      drain("t5", 20);

      // 6: RUN write ignored, reset mid-run, start+write applies write only
      bus.issue_ready = 1'b0;
      start_run(4'd4);
      wr(3'd0, 5'b11_1_00);
      reset = 1'b1;
      tick();
      chk("t6_reset", 32'({bus.op, bus.dest, bus.issue_valid, bus.pc, bus.busy, bus.done}), 32'd0);
      reset = 1'b0;
      tick();
      bus.start = 1'b1;
      bus.prog_len = 4'd2;
      wr(3'd1, 5'b11_0_00);
      bus.start = 1'b0;
      chk("t6_start_wr", 32'({bus.issue_valid, bus.busy, bus.done}), 32'd0);
      bus.issue_ready = 1'b1;
      push_prog(p5[0], 3'd0);
      push_prog(5'b11_0_00, 3'd1);
      push_done();
      start_run(4'd2);
      drain("t6", 20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
